// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: collects one frame of RGB pixels from the UART pixel
// assembler into a single-port frame RAM, locks the completed frame until the
// consumer releases it, and interleaves consumer reads around pixel writes.
// Writes always win the RAM port; a blocked read simply stays pending because
// the requester holds rd_req/rd_addr until rd_gnt.
// Optional build macro: FB_ADDR_CHECK_EN drops and flags writes whose address
// is at or beyond FRAME_PIXELS (addr_err). Without it addr_err is tied low.
//
// state | meaning
// IDLE  | no frame in progress, waiting for the first accepted write
// RECV  | frame being written, waiting for wr_frame_done
// READY | complete frame locked in RAM, writes dropped until rd_release
module frame_buffer_arbiter #(
    parameter int FRAME_PIXELS = 40800,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_pixel_done,
    input  logic [ADDR_W-1:0] wr_pixel_cnt,
    input  logic [23:0]       wr_rgb,
    input  logic              wr_frame_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [23:0]       rd_data,
    input  logic              rd_release,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [23:0]       ram_wdata,
    input  logic [23:0]       ram_rdata,
    output logic              frame_ready,
    output logic              overrun,
    output logic              addr_err,
    output logic [ADDR_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LP_COUNT_MAX = ADDR_W'(FRAME_PIXELS);

    state_t            r_state;
    logic              r_frame_ready;
    logic              r_overrun;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_wr_count;

    logic w_addr_ok;
    logic w_wr_accept;
    logic w_wr_drop;
    logic w_rd_issue;
    logic w_to_idle;

`ifdef FB_ADDR_CHECK_EN
    // Compare one bit wider so FRAME_PIXELS == 2**ADDR_W still works.
    localparam logic [ADDR_W:0] LP_FRAME_LIMIT = (ADDR_W+1)'(FRAME_PIXELS);
    logic r_addr_err;
    logic w_addr_bad;

    assign w_addr_ok  = ({1'b0, wr_pixel_cnt} < LP_FRAME_LIMIT);
    assign w_addr_bad = wr_pixel_done && (r_state != S_READY) && !w_addr_ok;

    // Sticky out-of-range flag, cleared only when the locked frame is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_to_idle) begin
            r_addr_err <= 1'b0;
        end else if (w_addr_bad) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;
`else
    assign w_addr_ok = 1'b1;
    assign addr_err  = 1'b0;
`endif

    // Writes never stall; a read takes the port only in cycles with no write.
    assign w_wr_accept = !reset && wr_pixel_done && (r_state != S_READY) && w_addr_ok;
    assign w_wr_drop   = wr_pixel_done && (r_state == S_READY);
    assign w_rd_issue  = !reset && rd_req && !w_wr_accept;
    assign w_to_idle   = (r_state == S_READY) && rd_release;

    // Combinational RAM port mux: write, else read, else all-zero idle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_gnt    = 1'b0;
        if (w_wr_accept) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_pixel_cnt;
            ram_wdata = wr_rgb;
        end else if (w_rd_issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr;
            rd_gnt   = 1'b1;
        end
    end

    // Frame FSM with registered frame_ready, write counter, overrun and read-valid pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_frame_ready <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_wr_count    <= '0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_wr_accept && (r_wr_count < LP_COUNT_MAX)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_wr_drop) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_wr_accept) begin
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A write coincident with wr_frame_done is already counted above.
                    if (wr_frame_done) begin
                        r_state       <= S_READY;
                        r_frame_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    // Release wins over a same-cycle dropped write: new frame starts clean.
                    if (rd_release) begin
                        r_state       <= S_IDLE;
                        r_frame_ready <= 1'b0;
                        r_overrun     <= 1'b0;
                        r_wr_count    <= '0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_frame_ready <= 1'b0;
                end
            endcase
        end
    end

    // The RAM registers its output, so data lines up with the cycle after the grant.
    assign rd_data     = r_rd_valid ? ram_rdata : 24'h0;
    assign rd_valid    = r_rd_valid;
    assign frame_ready = r_frame_ready;
    assign overrun     = r_overrun;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a 1-cycle-latency RAM model
// and a scoreboard queue of expected read data.
module tb_frame_buffer_arbiter;

    localparam int FP = 40800;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_pixel_done;
    logic [AW-1:0] wr_pixel_cnt;
    logic [23:0]   wr_rgb;
    logic          wr_frame_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [23:0]   rd_data;
    logic          rd_release;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [23:0]   ram_wdata;
    logic [23:0]   ram_rdata = 24'h0;
    logic          frame_ready;
    logic          overrun;
    logic          addr_err;
    logic [AW-1:0] wr_count;

    logic [23:0] mem     [0:65535];
    logic [23:0] exp_mem [0:65535];
    logic [23:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_pixel_done(wr_pixel_done), .wr_pixel_cnt(wr_pixel_cnt), .wr_rgb(wr_rgb),
        .wr_frame_done(wr_frame_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_release(rd_release),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .frame_ready(frame_ready), .overrun(overrun), .addr_err(addr_err),
        .wr_count(wr_count)
    );

    // Single-port RAM, registered read data
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid must match the oldest expected read
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 48'(rd_valid), 48'h0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("rd_data", 48'(rd_data), 48'(e));
            end
        end
    end

    function automatic logic [23:0] pix(input int i, input int seed);
        return 24'((i * 40503 + seed * 977) ^ 24'h5a5a5a);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wpd, input int wa, input logic [23:0] rgb,
                         input logic wfd, input logic rr, input int ra, input logic rel);
        wr_pixel_done = wpd;
        wr_pixel_cnt  = AW'(wa);
        wr_rgb        = rgb;
        wr_frame_done = wfd;
        rd_req        = rr;
        rd_addr       = AW'(ra);
        rd_release    = rel;
    endtask

    task automatic idle();
        drive(1'b0, 0, 24'h0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int rd_list [3];
        logic [23:0] v;
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 24'h0;
            exp_mem[a] = 24'h0;
        end
        rd_list[0] = FP - 1;
        rd_list[1] = 0;
        rd_list[2] = 20000;

        // Reset with requests active: port must stay quiet
        reset = 1'b1;
        idle();
        cyc();
        drive(1'b1, 7, 24'h111111, 1'b0, 1'b1, 2, 1'b0);
        #3;
        chk("rst_ram_en", 48'(ram_en), 48'h0);
        chk("rst_ram_we", 48'(ram_we), 48'h0);
        chk("rst_rd_gnt", 48'(rd_gnt), 48'h0);
        cyc();
        chk("rst_wr_count", 48'(wr_count), 48'h0);
        chk("rst_frame_ready", 48'(frame_ready), 48'h0);
        chk("rst_overrun", 48'(overrun), 48'h0);
        chk("rst_addr_err", 48'(addr_err), 48'h0);
        chk("rst_rd_valid", 48'(rd_valid), 48'h0);
        reset = 1'b0;
        idle();
        cyc();

        // frame_done and release in IDLE are ignored
        drive(1'b0, 0, 24'h0, 1'b1, 1'b0, 0, 1'b1);
        cyc();
        idle();
        chk("idle_fd_ignored", 48'(frame_ready), 48'h0);
        chk("idle_count", 48'(wr_count), 48'h0);

        // Read in IDLE
        drive(1'b0, 0, 24'h0, 1'b0, 1'b1, 100, 1'b0);
        #3;
        chk("idle_rd_gnt", 48'(rd_gnt), 48'h1);
        chk("idle_rd_addr", 48'(ram_addr), 48'd100);
        chk("idle_rd_we", 48'(ram_we), 48'h0);
        exp_q.push_back(exp_mem[100]);
        cyc();
        idle();

        // Full frame; last write coincides with wr_frame_done
        for (int i = 0; i < FP; i++) begin
            v = pix(i, 0);
            drive(1'b1, i, v, (i == FP - 1), 1'b0, 0, 1'b0);
            exp_mem[i] = v;
            if (i == 0 || i == FP - 1) begin
                #3;
                chk("fill_ram_en", 48'(ram_en), 48'h1);
                chk("fill_ram_we", 48'(ram_we), 48'h1);
                chk("fill_ram_addr", 48'(ram_addr), 48'(i));
                chk("fill_ram_wdata", 48'(ram_wdata), 48'(v));
            end
            if (i == 1000) begin
                chk("fill_count_mid", 48'(wr_count), 48'd1000);
                chk("fill_not_ready", 48'(frame_ready), 48'h0);
            end
            cyc();
        end
        idle();
        chk("full_count", 48'(wr_count), 48'(FP));
        chk("full_ready", 48'(frame_ready), 48'h1);
        chk("full_overrun", 48'(overrun), 48'h0);

        // Locked: write dropped, read in the same cycle still issued
        drive(1'b1, 3, 24'hFFFFFF, 1'b0, 1'b1, 3, 1'b0);
        #3;
        chk("lock_ram_we", 48'(ram_we), 48'h0);
        chk("lock_rd_gnt", 48'(rd_gnt), 48'h1);
        chk("lock_ram_addr", 48'(ram_addr), 48'd3);
        exp_q.push_back(exp_mem[3]);
        cyc();
        idle();
        chk("lock_overrun", 48'(overrun), 48'h1);
        chk("lock_ready", 48'(frame_ready), 48'h1);
        chk("lock_count", 48'(wr_count), 48'(FP));

        // Back-to-back reads in READY; frame_done there is ignored
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 24'h0, (k == 0), 1'b1, rd_list[k], 1'b0);
            #3;
            chk("b2b_rd_gnt", 48'(rd_gnt), 48'h1);
            chk("b2b_ram_addr", 48'(ram_addr), 48'(rd_list[k]));
            exp_q.push_back(exp_mem[rd_list[k]]);
            cyc();
            chk("b2b_rd_valid", 48'(rd_valid), 48'h1);
        end
        idle();
        chk("ready_kept", 48'(frame_ready), 48'h1);

        // Release
        drive(1'b0, 0, 24'h0, 1'b0, 1'b0, 0, 1'b1);
        cyc();
        idle();
        chk("rel_ready", 48'(frame_ready), 48'h0);
        chk("rel_overrun", 48'(overrun), 48'h0);
        chk("rel_count", 48'(wr_count), 48'h0);

        // Out-of-range write at FRAME_PIXELS
        drive(1'b1, FP, 24'hABCDEF, 1'b0, 1'b0, 0, 1'b0);
        #3;
`ifdef FB_ADDR_CHECK_EN
        chk("oor_ram_we", 48'(ram_we), 48'h0);
        chk("oor_ram_en", 48'(ram_en), 48'h0);
        cyc();
        idle();
        chk("oor_addr_err", 48'(addr_err), 48'h1);
        chk("oor_count", 48'(wr_count), 48'h0);
        drive(1'b0, 0, 24'h0, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        idle();
        chk("oor_still_idle", 48'(frame_ready), 48'h0);
`else
        chk("oor_ram_we", 48'(ram_we), 48'h1);
        chk("oor_ram_addr", 48'(ram_addr), 48'(FP));
        exp_mem[FP] = 24'hABCDEF;
        cyc();
        idle();
        chk("oor_addr_err", 48'(addr_err), 48'h0);
        chk("oor_count", 48'(wr_count), 48'h1);
        drive(1'b0, 0, 24'h0, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        idle();
        chk("oor_recv_ready", 48'(frame_ready), 48'h1);
        drive(1'b0, 0, 24'h0, 1'b0, 1'b0, 0, 1'b1);
        cyc();
        idle();
        chk("oor_released", 48'(frame_ready), 48'h0);
        chk("oor_rel_count", 48'(wr_count), 48'h0);
`endif

        // Short frame with write/read collision
        for (int i = 0; i < 9; i++) begin
            v = pix(i, 1);
            drive(1'b1, i, v, 1'b0, 1'b0, 0, 1'b0);
            exp_mem[i] = v;
            cyc();
        end
        v = pix(9, 1);
        drive(1'b1, 9, v, 1'b0, 1'b1, 5, 1'b0);
        exp_mem[9] = v;
        #3;
        chk("col_ram_we", 48'(ram_we), 48'h1);
        chk("col_ram_addr", 48'(ram_addr), 48'd9);
        chk("col_rd_gnt", 48'(rd_gnt), 48'h0);
        cyc();
        drive(1'b0, 0, 24'h0, 1'b0, 1'b1, 5, 1'b0);
        #3;
        chk("col_late_gnt", 48'(rd_gnt), 48'h1);
        chk("col_late_addr", 48'(ram_addr), 48'd5);
        chk("col_late_we", 48'(ram_we), 48'h0);
        exp_q.push_back(exp_mem[5]);
        cyc();
        idle();
        chk("col_rd_valid", 48'(rd_valid), 48'h1);
        drive(1'b0, 0, 24'h0, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        idle();
        chk("f2_ready", 48'(frame_ready), 48'h1);
        chk("f2_count", 48'(wr_count), 48'd10);
`ifdef FB_ADDR_CHECK_EN
        chk("f2_addr_err_sticky", 48'(addr_err), 48'h1);
`endif
        drive(1'b0, 0, 24'h0, 1'b0, 1'b0, 0, 1'b1);
        cyc();
        idle();
        chk("f2_released", 48'(frame_ready), 48'h0);
        chk("f2_addr_err_clr", 48'(addr_err), 48'h0);

        // Reset the cycle after a grant, mid-frame
        v = pix(20, 2);
        drive(1'b1, 20, v, 1'b0, 1'b0, 0, 1'b0);
        exp_mem[20] = v;
        cyc();
        drive(1'b0, 0, 24'h0, 1'b0, 1'b1, 20, 1'b0);
        #3;
        chk("mr_rd_gnt", 48'(rd_gnt), 48'h1);
        exp_q.push_back(exp_mem[20]);
        cyc();
        reset = 1'b1;
        #3;
        chk("mr_rst_gnt", 48'(rd_gnt), 48'h0);
        chk("mr_rst_en", 48'(ram_en), 48'h0);
        cyc();
        reset = 1'b0;
        idle();
        chk("mr_rd_valid", 48'(rd_valid), 48'h0);
        chk("mr_count", 48'(wr_count), 48'h0);
        drive(1'b0, 0, 24'h0, 1'b1, 1'b0, 0, 1'b0);
        cyc();
        idle();
        chk("mr_idle", 48'(frame_ready), 48'h0);

        // RAM contents survive reset
        drive(1'b0, 0, 24'h0, 1'b0, 1'b1, 20, 1'b0);
        #3;
        chk("post_rst_gnt", 48'(rd_gnt), 48'h1);
        exp_q.push_back(exp_mem[20]);
        cyc();
        idle();
        cyc();
        cyc();
        chk("scoreboard_drained", 48'(exp_q.size()), 48'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 The block SHALL have parameter FRAME_PIXELS, default 40800, meaning the pixel count of one complete frame.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the frame RAM address width.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port wr_pixel_done  input  1  one-cycle write strobe from the UART pixel assembler.
REQ-006 The block SHALL have port wr_pixel_cnt  input  ADDR_W  write address.
REQ-007 The block SHALL have port wr_rgb  input  24  write data.
REQ-008 The block SHALL have port wr_frame_done  input  1  one-cycle end-of-frame pulse from the assembler.
REQ-009 The block SHALL have port rd_req  input  1  read request, level.
REQ-010 The block SHALL have port rd_addr  input  ADDR_W  read address, held with rd_req.
REQ-011 The block SHALL have port rd_gnt  output  1  read issued to RAM this cycle.
REQ-012 The block SHALL have port rd_valid  output  1  rd_data valid.
REQ-013 The block SHALL have port rd_data  output  24  read data.
REQ-014 The block SHALL have port rd_release  input  1  one-cycle pulse: consumer has finished with the frame.
REQ-015 The block SHALL have ports ram_en, ram_we  output  1 each,  ram_addr  output  ADDR_W,  ram_wdata  output  24, and ram_rdata  input  24, for a single-port RAM with 1-cycle read latency.
REQ-016 The block SHALL have port frame_ready  output  1  complete frame locked in RAM.
REQ-017 The block SHALL have ports overrun  output  1  sticky: write dropped while locked, and addr_err  output  1  sticky: out-of-range write.
REQ-018 The block SHALL have port wr_count  output  ADDR_W  accepted writes in the current frame.

Function
REQ-019 The FSM SHALL have states IDLE, RECV and READY.
- IDLE->RECV on the first accepted write.
- RECV->READY on wr_frame_done.
- READY->IDLE on rd_release.
REQ-020 wr_frame_done in IDLE or READY SHALL be ignored, and rd_release in IDLE or RECV SHALL be ignored.
REQ-021 Writes SHALL be accepted in IDLE and RECV only: ram_en=1, ram_we=1, ram_addr=wr_pixel_cnt and ram_wdata=wr_rgb, driven combinationally in the strobe cycle.
REQ-022 A write strobe in READY SHALL be dropped and SHALL set overrun on the next edge.
REQ-023 A write strobe coincident with wr_frame_done in RECV SHALL be performed and counted, then the FSM SHALL enter READY.
REQ-024 Write SHALL have fixed priority over read; writes are never stalled.
REQ-025 Reads SHALL be allowed in every state.
- A read is issued when rd_req=1 and no write is accepted that cycle.
- Issue drives ram_en=1, ram_we=0, ram_addr=rd_addr and rd_gnt=1, all combinational.
REQ-026 A dropped write (READY) SHALL NOT block a read in the same cycle.
REQ-027 rd_valid SHALL be 1 exactly one cycle after rd_gnt, with rd_data=ram_rdata registered; back-to-back grants SHALL yield back-to-back valids.
REQ-028 The requester SHALL hold rd_req and rd_addr until rd_gnt; the arbiter SHALL keep a blocked read pending with no loss.
REQ-029 When neither a write nor a read is issued, the RAM outputs SHALL be ram_en=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-030 wr_count SHALL increment on each accepted write, saturate at FRAME_PIXELS, and clear on the READY->IDLE transition.
REQ-031 frame_ready SHALL be 1 exactly while in READY, as a registered state decode.
REQ-032 overrun and addr_err SHALL clear only on reset or on the READY->IDLE transition.

Reset
REQ-033 On reset the FSM SHALL go to IDLE and wr_count, rd_valid, rd_data, frame_ready, overrun and addr_err SHALL be 0.
REQ-034 While reset is high, the combinational RAM outputs and rd_gnt SHALL be forced to 0.
REQ-035 Reset mid-frame or mid-read SHALL discard the pending rd_valid and all state within one cycle; RAM contents are not cleared.

Configuration
REQ-036 With FB_ADDR_CHECK_EN defined, a write with wr_pixel_cnt >= FRAME_PIXELS SHALL be dropped, SHALL not be counted, SHALL not cause IDLE->RECV, and SHALL set addr_err.
REQ-037 With FB_ADDR_CHECK_EN undefined, every write in IDLE/RECV SHALL pass to RAM unchecked and addr_err SHALL be tied 0.

Verification
REQ-038 Frame fill: 40800 strobes at addr 0..40799, then wr_frame_done -> wr_count=40800, frame_ready=1 on the next edge, overrun=0.
REQ-039 Collision: rd_req=1 with rd_addr=5, and wr_pixel_done at addr 9 in the same cycle -> write issued, rd_gnt=0; next cycle rd_gnt=1, ram_addr=5; one cycle later rd_valid=1 with rd_data=RAM[5].
REQ-040 Lock: in READY, strobe at addr 3 with rgb 0xFFFFFF -> ram_we stays 0, overrun=1, RAM[3] unchanged; then rd_release -> IDLE, frame_ready=0, overrun=0, wr_count=0.
REQ-041 Simultaneous last write and frame_done at addr 40799 -> write issued, wr_count=40800, state READY.
REQ-042 With FB_ADDR_CHECK_EN, strobe at addr 40800 -> ram_we=0, addr_err=1, state stays IDLE; without the macro, ram_we=1 and addr_err=0.
REQ-043 Reset asserted the cycle after rd_gnt -> rd_valid=0 next cycle and state IDLE.
